// File: rtl/quiz_pkg.sv
// Shared types and constants for the quiz-buzzer round controller.
// Contents: round state enum, question/beep lengths, seven-segment patterns
// (active-low {dp,g,f,e,d,c,b,a}), BCD helpers.
package quiz_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      HELD    = 2'd2,
      TIMEOUT = 2'd3
   } state_t;

   // Question lengths held directly in BCD (tens in [7:4], ones in [3:0]).
   localparam logic [7:0] LOAD_SHORT_BCD = 8'h20;
   localparam logic [7:0] LOAD_LONG_BCD  = 8'h30;

   localparam logic [6:0] BEEP_ANSWER    = 7'd20;
   localparam logic [6:0] BEEP_TIMEOUT   = 7'd100;
   localparam logic [6:0] TICKS_PER_SEC  = 7'd100;
   localparam logic [6:0] SCORE_MAX      = 7'd99;

   localparam logic [7:0] SEG_BLANK      = 8'hFF;

   // Active-low segment pattern for a decimal digit; anything above 9 is blank.
   function automatic logic [7:0] seg_pattern(input logic [3:0] d);
      logic [7:0] p;
      case (d)
         4'd0:    p = 8'hC0;
         4'd1:    p = 8'hF9;
         4'd2:    p = 8'hA4;
         4'd3:    p = 8'hB0;
         4'd4:    p = 8'h99;
         4'd5:    p = 8'h92;
         4'd6:    p = 8'h82;
         4'd7:    p = 8'hF8;
         4'd8:    p = 8'h80;
         4'd9:    p = 8'h90;
         default: p = SEG_BLANK;
      endcase
      return p;
   endfunction

   // Two-digit BCD decrement; callers never decrement 00.
   function automatic logic [7:0] bcd_dec(input logic [7:0] b);
      logic [7:0] r;
      if (b[3:0] == 4'd0) r = {b[7:4] - 4'd1, 4'd9};
      else                r = {b[7:4], b[3:0] - 4'd1};
      return r;
   endfunction

   // Binary 0..99 to two BCD digits.
   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

endpackage

// File: rtl/answer_parts_if.sv
// Board-side signal bundle of the quiz round controller.
// master: the game controller / board side (drives buttons, keypad rows).
// slave : answer_parts (drives keypad columns, display, LEDs, beeper, flags).
interface answer_parts_if;
   logic       start;
   logic       time_select;
   logic [3:0] answer;
   logic       yes;
   logic       no;
   logic       select1;
   logic       select2;
   logic [3:0] row;
   logic [3:0] col;
   logic [7:0] seg_out;
   logic [7:0] seg_en;
   logic [3:0] answer_led;
   logic       alarm;
   logic       answered;
   logic       time_over;

   modport master (
      output start, time_select, answer, yes, no, select1, select2, row,
      input  col, seg_out, seg_en, answer_led, alarm, answered, time_over
   );

   modport slave (
      input  start, time_select, answer, yes, no, select1, select2, row,
      output col, seg_out, seg_en, answer_led, alarm, answered, time_over
   );
endinterface

// File: rtl/answer_parts_frequency_divider.sv
// frequency_divider: emits a one-clock pulse every PERIOD clocks.
// Ports: clk, rst (async, active-high; clears the counter), pulse (out).
module frequency_divider #(
   parameter int PERIOD = 10
) (
   input  logic clk,
   input  logic rst,
   output logic pulse
);
   localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [W-1:0] LAST = W'(PERIOD - 1);

   logic [W-1:0] cnt_q, cnt_d;
   logic         pulse_q, pulse_d;

   always_comb begin
      cnt_d   = cnt_q + 1'b1;
      pulse_d = 1'b0;
      if (cnt_q == LAST) begin
         cnt_d   = '0;
         pulse_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;
endmodule

// File: rtl/answer_parts.sv
// answer_parts: quiz-buzzer round controller.
// Owns the question countdown (BCD seconds), first-press arbitration among
// 2..4 players, judge scoring, keypad point selector, beeper and the 8-digit
// multiplexed seven-segment display.
// Ports: clk, rst (async, active-high), bus (answer_parts_if.slave) carrying
// start/time_select/answer/yes/no/select1/select2/row in and
// col/seg_out/seg_en/answer_led/alarm/answered/time_over out.
module answer_parts
   import quiz_pkg::*;
#(
   parameter int TICK_PERIOD = 1_000_000,
   parameter int SCAN_PERIOD = 100_000
) (
   input  logic          clk,
   input  logic          rst,
   answer_parts_if.slave bus
);
   // Raw inputs packed as {start, time_select, answer[3:0], yes, no,
   // select1, select2, row[3:0]}. Rows idle high, so they reset to 1.
   localparam logic [13:0] SYNC_RESET = 14'h000F;

   logic        tick, scan;

   logic [13:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic        yes_prev_q, yes_prev_d, no_prev_q, no_prev_d;
   logic        yes_rise_q, yes_rise_d, no_rise_q, no_rise_d;
   state_t      state_q, state_d;
   logic        time_sel_q, time_sel_d;
   logic [7:0]  timer_q, timer_d;
   logic [6:0]  sub_q, sub_d;
   logic [6:0]  beep_q, beep_d;
   logic [1:0]  winner_q, winner_d;
   logic        answered_q, answered_d;
   logic [3:0]  led_q, led_d;
   logic        time_over_q, time_over_d;
   logic        alarm_q, alarm_d;
   logic [6:0]  score_q [4];
   logic [6:0]  score_d [4];
   logic [3:0]  point_q, point_d;
   logic [1:0]  col_idx_q, col_idx_d;
   logic [3:0]  col_q, col_d;
   logic [2:0]  dig_q, dig_d;
   logic [7:0]  seg_out_q, seg_out_d;
   logic [7:0]  seg_en_q, seg_en_d;

   logic        start_s, time_sel_s, yes_s, no_s, select1_s, select2_s;
   logic [3:0]  answer_s, row_s;
   logic [3:0]  enable_mask, req;
   logic [1:0]  req_idx;
   logic [7:0]  score_sum;
   logic [7:0]  score_bcd;
   logic        key_hit;
   logic [1:0]  key_row;
   logic [3:0]  disp_val;
   logic        disp_blank;

   frequency_divider #(.PERIOD(TICK_PERIOD)) u_tick (.clk(clk), .rst(rst), .pulse(tick));
   frequency_divider #(.PERIOD(SCAN_PERIOD)) u_scan (.clk(clk), .rst(rst), .pulse(scan));

   assign start_s    = sync2_q[13];
   assign time_sel_s = sync2_q[12];
   assign answer_s   = sync2_q[11:8];
   assign yes_s      = sync2_q[7];
   assign no_s       = sync2_q[6];
   assign select1_s  = sync2_q[5];
   assign select2_s  = sync2_q[4];
   assign row_s      = sync2_q[3:0];

   always_comb begin
      sync1_d     = {bus.start, bus.time_select, bus.answer, bus.yes, bus.no,
                     bus.select1, bus.select2, bus.row};
      sync2_d     = sync1_q;
      yes_prev_d  = yes_s;
      no_prev_d   = no_s;
      yes_rise_d  = yes_s & ~yes_prev_q;
      no_rise_d   = no_s & ~no_prev_q;

      state_d     = state_q;
      time_sel_d  = time_sel_q;
      timer_d     = timer_q;
      sub_d       = sub_q;
      beep_d      = beep_q;
      winner_d    = winner_q;
      answered_d  = answered_q;
      led_d       = led_q;
      time_over_d = time_over_q;
      score_d     = score_q;
      point_d     = point_q;
      col_idx_d   = col_idx_q;
      col_d       = col_q;
      dig_d       = dig_q;
      seg_out_d   = seg_out_q;
      seg_en_d    = seg_en_q;

      // Player count: {select2,select1} 00 -> 2, 01 -> 3, 1x -> 4.
      enable_mask = select2_s ? 4'b1111 : (select1_s ? 4'b0111 : 4'b0011);
      req         = answer_s & enable_mask;
      req_idx     = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (req[i]) req_idx = 2'(i);   // descending scan leaves the lowest index
      end

      score_sum = {1'b0, score_q[winner_q]} + {4'b0000, point_q};
      score_bcd = to_bcd(score_q[winner_q]);

      if (tick && beep_q != 7'd0) beep_d = beep_q - 7'd1;

      case (state_q)
         IDLE: begin
            time_sel_d  = time_sel_s;
            timer_d     = time_sel_s ? LOAD_LONG_BCD : LOAD_SHORT_BCD;
            sub_d       = 7'd0;
            answered_d  = 1'b0;
            led_d       = 4'b0000;
            time_over_d = 1'b0;
            if (start_s) state_d = RUN;
         end
         RUN: begin
            // A press in the same cycle as the final tick still counts.
            if (req != 4'b0000) begin
               state_d    = HELD;
               winner_d   = req_idx;
               answered_d = 1'b1;
               led_d      = 4'b0001 << req_idx;
               beep_d     = BEEP_ANSWER;
            end else if (tick) begin
               if (sub_q == TICKS_PER_SEC - 7'd1) begin
                  sub_d   = 7'd0;
                  timer_d = bcd_dec(timer_q);
                  if (timer_d == 8'h00) begin
                     state_d     = TIMEOUT;
                     time_over_d = 1'b1;
                     beep_d      = BEEP_TIMEOUT;
                  end
               end else begin
                  sub_d = sub_q + 7'd1;
               end
            end
         end
         HELD: begin
            if (yes_rise_q || no_rise_q) begin
               if (yes_rise_q) begin
                  score_d[winner_q] = (score_sum > 8'(SCORE_MAX)) ? SCORE_MAX : score_sum[6:0];
               end
               state_d    = RUN;
               answered_d = 1'b0;
               led_d      = 4'b0000;
               timer_d    = time_sel_q ? LOAD_LONG_BCD : LOAD_SHORT_BCD;
               sub_d      = 7'd0;
            end
         end
         default: ;  // TIMEOUT holds until start drops
      endcase

      if (!start_s) state_d = IDLE;

      // Keypad: rows are sampled just before the column advances, so the
      // synchronized rows have long settled for the column being driven.
      key_hit = 1'b0;
      key_row = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (!row_s[r]) begin
            key_hit = 1'b1;
            key_row = 2'(r);
         end
      end

      disp_val   = 4'd0;
      disp_blank = 1'b0;
      case (dig_q)
         3'd0:    disp_val = (state_q == HELD) ? score_bcd[3:0] : timer_q[3:0];
         3'd1:    disp_val = (state_q == HELD) ? score_bcd[7:4] : timer_q[7:4];
         3'd7:    disp_val = (state_q == HELD) ? {2'b00, winner_q} + 4'd1 : point_q;
         default: disp_blank = 1'b1;
      endcase

      if (scan) begin
         if (state_q == IDLE && key_hit && key_row != 2'd3 && col_idx_q != 2'd3) begin
            point_d = {2'b00, key_row} * 4'd3 + {2'b00, col_idx_q} + 4'd1;
         end
         col_idx_d = col_idx_q + 2'd1;
         col_d     = ~(4'b0001 << col_idx_d);
         seg_out_d = disp_blank ? SEG_BLANK : seg_pattern(disp_val);
         seg_en_d  = disp_blank ? 8'hFF : ~(8'b0000_0001 << dig_q);
         dig_d     = dig_q + 3'd1;
      end

      alarm_d = (beep_d != 7'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= SYNC_RESET;
         sync2_q     <= SYNC_RESET;
         yes_prev_q  <= 1'b0;
         no_prev_q   <= 1'b0;
         yes_rise_q  <= 1'b0;
         no_rise_q   <= 1'b0;
         state_q     <= IDLE;
         time_sel_q  <= 1'b0;
         timer_q     <= LOAD_SHORT_BCD;
         sub_q       <= 7'd0;
         beep_q      <= 7'd0;
         winner_q    <= 2'd0;
         answered_q  <= 1'b0;
         led_q       <= 4'b0000;
         time_over_q <= 1'b0;
         alarm_q     <= 1'b0;
         for (int i = 0; i < 4; i++) score_q[i] <= 7'd0;
         point_q     <= 4'd1;
         col_idx_q   <= 2'd0;
         col_q       <= 4'b1110;
         dig_q       <= 3'd0;
         seg_out_q   <= 8'hFF;
         seg_en_q    <= 8'hFF;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         yes_prev_q  <= yes_prev_d;
         no_prev_q   <= no_prev_d;
         yes_rise_q  <= yes_rise_d;
         no_rise_q   <= no_rise_d;
         state_q     <= state_d;
         time_sel_q  <= time_sel_d;
         timer_q     <= timer_d;
         sub_q       <= sub_d;
         beep_q      <= beep_d;
         winner_q    <= winner_d;
         answered_q  <= answered_d;
         led_q       <= led_d;
         time_over_q <= time_over_d;
         alarm_q     <= alarm_d;
         score_q     <= score_d;
         point_q     <= point_d;
         col_idx_q   <= col_idx_d;
         col_q       <= col_d;
         dig_q       <= dig_d;
         seg_out_q   <= seg_out_d;
         seg_en_q    <= seg_en_d;
      end
   end

   assign bus.col        = col_q;
   assign bus.seg_out    = seg_out_q;
   assign bus.seg_en     = seg_en_q;
   assign bus.answer_led = led_q;
   assign bus.alarm      = alarm_q;
   assign bus.answered   = answered_q;
   assign bus.time_over  = time_over_q;
endmodule

// File: tb/tb_answer_parts.sv
// Directed testbench for answer_parts (TICK_PERIOD = 10, SCAN_PERIOD = 4).
module tb_answer_parts;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   logic       key_on;
   logic [1:0] key_r, key_c;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   answer_parts_if bus();

   answer_parts #(.TICK_PERIOD(10), .SCAN_PERIOD(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Keypad matrix: the held key pulls its row low while its column is driven.
   assign bus.row = (key_on && bus.col[key_c] == 1'b0) ? ~(4'b0001 << key_r) : 4'b1111;

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_buzzer(input logic [3:0] m);
      @(negedge clk);
      bus.answer = m;
      @(negedge clk);
      bus.answer = 4'b0000;
      $display("[%0t] buzzer press %b", $time, m);
   endtask

   task automatic pulse_judge(input logic y, input logic n);
      @(negedge clk);
      bus.yes = y;
      bus.no  = n;
      @(negedge clk);
      bus.yes = 1'b0;
      bus.no  = 1'b0;
      $display("[%0t] judge yes=%b no=%b", $time, y, n);
   endtask

   task automatic press_key(input logic [1:0] r, input logic [1:0] c);
      key_r  = r;
      key_c  = c;
      key_on = 1'b1;
      wait_clks(64);
      key_on = 1'b0;
      wait_clks(8);
      $display("[%0t] keypad row %0d col %0d", $time, r, c);
   endtask

   // Waits for the display to refresh, then captures the pattern of digit d.
   task automatic read_digit(input int d, output logic [7:0] seg, output bit ok);
      logic [7:0] want_en;
      want_en = ~(8'b0000_0001 << d);
      ok  = 1'b0;
      seg = 8'h00;
      wait_clks(36);
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.seg_en === want_en) begin
            ok  = 1'b1;
            seg = bus.seg_out;
         end
      end
      $display("[%0t] digit %0d read %h (found=%0d)", $time, d, seg, ok);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_clks(3);
      n_cmp++; if (bus.seg_out !== 8'hFF) begin n_err++; $display("FAIL reset_seg_out: got %h want ff", bus.seg_out); end
      n_cmp++; if (bus.seg_en !== 8'hFF) begin n_err++; $display("FAIL reset_seg_en: got %h want ff", bus.seg_en); end
      n_cmp++; if (bus.col !== 4'b1110) begin n_err++; $display("FAIL reset_col: got %b want 1110", bus.col); end
      n_cmp++; if (bus.answer_led !== 4'b0000) begin n_err++; $display("FAIL reset_led: got %b want 0000", bus.answer_led); end
      n_cmp++; if (bus.alarm !== 1'b0) begin n_err++; $display("FAIL reset_alarm: got %b want 0", bus.alarm); end
      n_cmp++; if (bus.answered !== 1'b0) begin n_err++; $display("FAIL reset_answered: got %b want 0", bus.answered); end
      n_cmp++; if (bus.time_over !== 1'b0) begin n_err++; $display("FAIL reset_time_over: got %b want 0", bus.time_over); end
      @(negedge clk);
      rst = 1'b0;
      wait_clks(4);
   endtask

   task automatic test_timeout();
      logic [7:0] seg;
      bit ok;
      int t0, guard, ac;
      bus.time_select = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      t0 = cyc;
      read_digit(1, seg, ok);
      n_cmp++; if (!ok || seg !== 8'hA4) begin n_err++; $display("FAIL to_tens20: got %h want a4", seg); end
      read_digit(0, seg, ok);
      n_cmp++; if (!ok || seg !== 8'hC0) begin n_err++; $display("FAIL to_ones20: got %h want c0", seg); end
      read_digit(7, seg, ok);
      n_cmp++; if (!ok || seg !== 8'hF9) begin n_err++; $display("FAIL to_point1: got %h want f9", seg); end
      guard = 0;
      while (bus.time_over !== 1'b1 && guard < 25000) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++; if (cyc - t0 < 19990 || cyc - t0 > 20010) begin n_err++; $display("FAIL to_duration: got %0d clocks want 19990..20010", cyc - t0); end
      n_cmp++; if (bus.alarm !== 1'b1) begin n_err++; $display("FAIL to_alarm_on: got %b want 1", bus.alarm); end
      ac = 0;
      while (bus.alarm === 1'b1 && ac < 3000) begin
         @(negedge clk);
         ac++;
      end
      n_cmp++; if (ac != 1000) begin n_err++; $display("FAIL to_alarm_len: got %0d clocks want 1000", ac); end
      read_digit(1, seg, ok);
      n_cmp++; if (!ok || seg !== 8'hC0) begin n_err++; $display("FAIL to_tens0: got %h want c0", seg); end
      read_digit(0, seg, ok);
      n_cmp++; if (!ok || seg !== 8'hC0) begin n_err++; $display("FAIL to_ones0: got %h want c0", seg); end
      press_buzzer(4'b0001);
      wait_clks(4);
      n_cmp++; if (bus.answered !== 1'b0) begin n_err++; $display("FAIL to_buzz_ignored: got %b want 0", bus.answered); end
      n_cmp++; if (bus.time_over !== 1'b1) begin n_err++; $display("FAIL to_hold: got %b want 1", bus.time_over); end
      bus.start = 1'b0;
      wait_clks(6);
      n_cmp++; if (bus.time_over !== 1'b0) begin n_err++; $display("FAIL to_idle_clear: got %b want 0", bus.time_over); end
   endtask

   task automatic test_arbitration();
      logic [7:0] seg;
      bit ok;
      bus.select2 = 1'b1;
      bus.select1 = 1'b0;
      wait_clks(5);
      bus.start = 1'b1;
      wait_clks(20);
      press_buzzer(4'b0110);
      @(negedge clk);
      n_cmp++; if (bus.answered !== 1'b0) begin n_err++; $display("FAIL arb_early: got %b want 0", bus.answered); end
      @(negedge clk);
      n_cmp++; if (bus.answered !== 1'b1) begin n_err++; $display("FAIL arb_answered: got %b want 1", bus.answered); end
      n_cmp++; if (bus.answer_led !== 4'b0010) begin n_err++; $display("FAIL arb_led: got %b want 0010", bus.answer_led); end
      n_cmp++; if (bus.alarm !== 1'b1) begin n_err++; $display("FAIL arb_beep: got %b want 1", bus.alarm); end
      read_digit(7, seg, ok);
      n_cmp++; if (!ok || seg !== 8'hA4) begin n_err++; $display("FAIL arb_player: got %h want a4", seg); end
      wait_clks(3000);
      n_cmp++; if (bus.answered !== 1'b1 || bus.time_over !== 1'b0) begin n_err++; $display("FAIL arb_held: got answered=%b time_over=%b want 1/0", bus.answered, bus.time_over); end
      pulse_judge(1'b0, 1'b1);
      wait_clks(2);
      n_cmp++; if (bus.answered !== 1'b1) begin n_err++; $display("FAIL no_early: got %b want 1", bus.answered); end
      @(negedge clk);
      n_cmp++; if (bus.answered !== 1'b0 || bus.answer_led !== 4'b0000) begin n_err++; $display("FAIL no_release: got %b/%b want 0/0000", bus.answered, bus.answer_led); end
   endtask

   task automatic test_player_count();
      bus.start = 1'b0;
      wait_clks(5);
      bus.select2 = 1'b0;
      bus.select1 = 1'b0;
      bus.start   = 1'b1;
      wait_clks(10);
      press_buzzer(4'b1000);
      wait_clks(5);
      n_cmp++; if (bus.answered !== 1'b0) begin n_err++; $display("FAIL cnt_ignored: got %b want 0", bus.answered); end
      press_buzzer(4'b0001);
      wait_clks(2);
      n_cmp++; if (bus.answered !== 1'b1 || bus.answer_led !== 4'b0001) begin n_err++; $display("FAIL cnt_capture: got %b/%b want 1/0001", bus.answered, bus.answer_led); end
      pulse_judge(1'b0, 1'b1);
      wait_clks(4);
   endtask

   task automatic test_score();
      logic [7:0] seg;
      bit ok;
      bus.start = 1'b0;
      wait_clks(10);
      press_key(2'd1, 2'd1);
      read_digit(7, seg, ok);
      n_cmp++; if (!ok || seg !== 8'h92) begin n_err++; $display("FAIL key5_point: got %h want 92", seg); end
      bus.select2 = 1'b1;
      bus.start   = 1'b1;
      wait_clks(1100);
      read_digit(0, seg, ok);
      n_cmp++; if (!ok || seg !== 8'h90) begin n_err++; $display("FAIL run_ones19: got %h want 90", seg); end
      read_digit(1, seg, ok);
      n_cmp++; if (!ok || seg !== 8'hF9) begin n_err++; $display("FAIL run_tens19: got %h want f9", seg); end
      press_key(2'd2, 2'd2);
      press_buzzer(4'b0100);
      wait_clks(2);
      n_cmp++; if (bus.answer_led !== 4'b0100) begin n_err++; $display("FAIL p3_led: got %b want 0100", bus.answer_led); end
      read_digit(7, seg, ok);
      n_cmp++; if (!ok || seg !== 8'hB0) begin n_err++; $display("FAIL p3_player: got %h want b0", seg); end
      read_digit(0, seg, ok);
      n_cmp++; if (!ok || seg !== 8'hC0) begin n_err++; $display("FAIL p3_score0: got %h want c0", seg); end
      pulse_judge(1'b1, 1'b0);
      wait_clks(2);
      n_cmp++; if (bus.answered !== 1'b1) begin n_err++; $display("FAIL yes_early: got %b want 1", bus.answered); end
      @(negedge clk);
      n_cmp++; if (bus.answered !== 1'b0) begin n_err++; $display("FAIL yes_release: got %b want 0", bus.answered); end
      read_digit(1, seg, ok);
      n_cmp++; if (!ok || seg !== 8'hA4) begin n_err++; $display("FAIL reload_tens: got %h want a4", seg); end
      read_digit(0, seg, ok);
      n_cmp++; if (!ok || seg !== 8'hC0) begin n_err++; $display("FAIL reload_ones: got %h want c0", seg); end
      press_buzzer(4'b0100);
      wait_clks(3);
      read_digit(0, seg, ok);
      n_cmp++; if (!ok || seg !== 8'h92) begin n_err++; $display("FAIL score5_ones: got %h want 92", seg); end
      read_digit(1, seg, ok);
      n_cmp++; if (!ok || seg !== 8'hC0) begin n_err++; $display("FAIL score5_tens: got %h want c0", seg); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] seg;
      bit ok;
      pulse_judge(1'b1, 1'b1);
      wait_clks(4);
      press_buzzer(4'b0100);
      wait_clks(3);
      read_digit(1, seg, ok);
      n_cmp++; if (!ok || seg !== 8'hF9) begin n_err++; $display("FAIL both_tens: got %h want f9", seg); end
      read_digit(0, seg, ok);
      n_cmp++; if (!ok || seg !== 8'hC0) begin n_err++; $display("FAIL both_ones: got %h want c0", seg); end
      for (int k = 0; k < 19; k++) begin
         pulse_judge(1'b1, 1'b0);
         wait_clks(4);
         press_buzzer(4'b0100);
         wait_clks(3);
      end
      read_digit(1, seg, ok);
      n_cmp++; if (!ok || seg !== 8'h90) begin n_err++; $display("FAIL sat_tens: got %h want 90", seg); end
      read_digit(0, seg, ok);
      n_cmp++; if (!ok || seg !== 8'h90) begin n_err++; $display("FAIL sat_ones: got %h want 90", seg); end
   endtask

   task automatic test_reset_mid_held();
      logic [7:0] seg;
      bit ok;
      n_cmp++; if (bus.answered !== 1'b1) begin n_err++; $display("FAIL pre_rst_held: got %b want 1", bus.answered); end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (bus.seg_out !== 8'hFF || bus.seg_en !== 8'hFF) begin n_err++; $display("FAIL arst_display: got %h/%h want ff/ff", bus.seg_out, bus.seg_en); end
      n_cmp++; if (bus.col !== 4'b1110) begin n_err++; $display("FAIL arst_col: got %b want 1110", bus.col); end
      n_cmp++; if (bus.answer_led !== 4'b0000 || bus.answered !== 1'b0) begin n_err++; $display("FAIL arst_capture: got %b/%b want 0000/0", bus.answer_led, bus.answered); end
      n_cmp++; if (bus.alarm !== 1'b0 || bus.time_over !== 1'b0) begin n_err++; $display("FAIL arst_flags: got %b/%b want 0/0", bus.alarm, bus.time_over); end
      @(negedge clk);
      rst = 1'b0;
      wait_clks(10);
      read_digit(7, seg, ok);
      n_cmp++; if (!ok || seg !== 8'hF9) begin n_err++; $display("FAIL arst_point: got %h want f9", seg); end
      press_buzzer(4'b0100);
      wait_clks(3);
      read_digit(0, seg, ok);
      n_cmp++; if (!ok || seg !== 8'hC0) begin n_err++; $display("FAIL arst_score_ones: got %h want c0", seg); end
      read_digit(1, seg, ok);
      n_cmp++; if (!ok || seg !== 8'hC0) begin n_err++; $display("FAIL arst_score_tens: got %h want c0", seg); end
   endtask

   initial begin
      rst             = 1'b1;
      key_on          = 1'b0;
      key_r           = 2'd0;
      key_c           = 2'd0;
      bus.start       = 1'b0;
      bus.time_select = 1'b0;
      bus.answer      = 4'b0000;
      bus.yes         = 1'b0;
      bus.no          = 1'b0;
      bus.select1     = 1'b0;
      bus.select2     = 1'b0;
      test_reset();
      test_timeout();
      test_arbitration();
      test_player_count();
      test_score();
      test_back_to_back();
      test_reset_mid_held();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
